// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared constants and tap-mask table for the lfsr_gen generator family.
// Masks are 0-indexed bit positions of the Fibonacci taps for each legal width.
package lfsr_pkg;

    localparam int unsigned LFSR_MIN_W = 3;
    localparam int unsigned LFSR_MAX_W = 16;

    localparam int unsigned MODE_FIB = 0;
    localparam int unsigned MODE_GAL = 1;

    typedef logic [LFSR_MAX_W-1:0] tap_mask_t;

    // Maximal-length taps, index = width; entries 0..2 are unused.
    localparam tap_mask_t LFSR_TAP_TABLE [LFSR_MAX_W+1] = '{
        16'h0000, 16'h0000, 16'h0000,
        16'h0006,  // 3 : x^3+x^2+1
        16'h000C,  // 4 : x^4+x^3+1
        16'h0014,  // 5 : x^5+x^3+1
        16'h0030,  // 6 : x^6+x^5+1
        16'h0060,  // 7 : x^7+x^6+1
        16'h00B8,  // 8 : x^8+x^6+x^5+x^4+1
        16'h0110,  // 9 : x^9+x^5+1
        16'h0240,  // 10: x^10+x^7+1
        16'h0500,  // 11: x^11+x^9+1
        16'h0829,  // 12: x^12+x^6+x^4+x+1
        16'h100D,  // 13: x^13+x^4+x^3+x+1
        16'h2015,  // 14: x^14+x^5+x^3+x+1
        16'h6000,  // 15: x^15+x^14+1
        16'hD008   // 16: x^16+x^15+x^13+x^4+1
    };

    // Fibonacci tap mask for a width; zero for out-of-range widths.
    function automatic tap_mask_t lfsr_taps(input int unsigned width);
        if (width < LFSR_MIN_W || width > LFSR_MAX_W) begin
            return '0;
        end
        return LFSR_TAP_TABLE[width[4:0]];
    endfunction

    // Galois form of the same polynomial: the Fibonacci mask mirrored within
    // the width, so bit 0 is always set and the step stays invertible.
    function automatic tap_mask_t lfsr_gal_taps(input int unsigned width);
        tap_mask_t fib;
        tap_mask_t gal;
        fib = lfsr_taps(width);
        gal = '0;
        for (int unsigned i = 0; i < width; i++) begin
            if (((fib >> i) & tap_mask_t'(1)) != '0) begin
                gal = gal | (tap_mask_t'(1) << (width - 1 - i));
            end
        end
        return gal;
    endfunction

endpackage

// File: rtl/lfsr_gen_if.sv
// lfsr_gen_if: control/data bundle between an LFSR consumer (master) and lfsr_gen (slave).
// Period-monitor signals exist only when LFSR_PERIOD_MON_EN is defined.
interface lfsr_gen_if #(
    parameter int unsigned WIDTH = 8
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] seed_in;
    logic [WIDTH-1:0] lfsr;
    logic             bit_out;
    logic             lockup;
`ifdef LFSR_PERIOD_MON_EN
    logic             period_done;
    logic [WIDTH-1:0] period_len;

    modport master (
        output en, load, seed_in,
        input  lfsr, bit_out, lockup, period_done, period_len
    );
    modport slave (
        input  en, load, seed_in,
        output lfsr, bit_out, lockup, period_done, period_len
    );
`else
    modport master (
        output en, load, seed_in,
        input  lfsr, bit_out, lockup
    );
    modport slave (
        input  en, load, seed_in,
        output lfsr, bit_out, lockup
    );
`endif
endinterface

// File: rtl/lfsr_period_mon.sv
// lfsr_period_mon: counts steps since the last (re)seed and flags the return to
// that seed. Built only when LFSR_PERIOD_MON_EN is defined.
module lfsr_period_mon #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,     // load or lock-up recovery on this edge
    input  logic             step,        // a normal LFSR step on this edge
    input  logic [WIDTH-1:0] next_state,  // state the generator takes on this edge
    output logic             period_done,
    output logic [WIDTH-1:0] period_len
);
    logic [WIDTH-1:0] seed_ref_q;
    logic [WIDTH-1:0] cnt_q;
    logic             done_q;
    logic [WIDTH-1:0] len_q;

    // Track the reference seed, step count and last completed period length.
    always_ff @(posedge clk) begin
        if (rst) begin
            seed_ref_q <= SEED;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            len_q      <= '0;
        end else begin
            done_q <= 1'b0;
            if (restart) begin
                seed_ref_q <= next_state;
                cnt_q      <= '0;
            end else if (step) begin
                if (next_state == seed_ref_q) begin
                    done_q <= 1'b1;
                    len_q  <= cnt_q + 1'b1;
                    cnt_q  <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign period_done = done_q;
    assign period_len  = len_q;

endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen: maximal-length LFSR generator, Fibonacci or Galois, with seed load
// and all-zero lock-up recovery. Define LFSR_PERIOD_MON_EN to add the period monitor.
// WIDTH must lie in LFSR_MIN_W..LFSR_MAX_W and SEED[WIDTH-1:0] must be non-zero.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned MODE  = MODE_FIB,
    parameter tap_mask_t   SEED  = 16'h002A
) (
    input logic       clk,
    input logic       rst,
    lfsr_gen_if.slave bus
);
    localparam tap_mask_t        TapsFull = (MODE == MODE_GAL) ? lfsr_gal_taps(WIDTH)
                                                               : lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] Taps     = TapsFull[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SeedW    = SEED[WIDTH-1:0];

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;
    logic [WIDTH-1:0] step_val;
    logic             lockup_q;
    logic             lockup_d;

    // One LFSR step from the current state in the configured form.
    always_comb begin
        step_val = lfsr_q;
        if (MODE == MODE_GAL) begin
            step_val = {lfsr_q[WIDTH-2:0], 1'b0} ^ (lfsr_q[WIDTH-1] ? Taps : '0);
        end else begin
            step_val = {lfsr_q[WIDTH-2:0], ^(lfsr_q & Taps)};
        end
    end

    // Next state: load beats step; a zero seed or zero state falls back to SEED.
    always_comb begin
        lfsr_d   = lfsr_q;
        lockup_d = 1'b0;
        if (bus.load) begin
            if (bus.seed_in != '0) begin
                lfsr_d = bus.seed_in;
            end else begin
                lfsr_d   = SeedW;
                lockup_d = 1'b1;
            end
        end else if (bus.en) begin
            if (lfsr_q == '0) begin
                lfsr_d   = SeedW;
                lockup_d = 1'b1;
            end else begin
                lfsr_d = step_val;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q   <= SeedW;
            lockup_q <= 1'b0;
        end else begin
            lfsr_q   <= lfsr_d;
            lockup_q <= lockup_d;
        end
    end

    assign bus.lfsr    = lfsr_q;
    assign bus.bit_out = lfsr_q[WIDTH-1];
    assign bus.lockup  = lockup_q;

`ifdef LFSR_PERIOD_MON_EN
    logic mon_restart;
    logic mon_step;

    // Any edge that installs a new reference seed restarts the period count.
    assign mon_restart = bus.load | lockup_d;
    assign mon_step    = bus.en & ~bus.load & (lfsr_q != '0);

    lfsr_period_mon #(
        .WIDTH (WIDTH),
        .SEED  (SeedW)
    ) u_period_mon (
        .clk         (clk),
        .rst         (rst),
        .restart     (mon_restart),
        .step        (mon_step),
        .next_state  (lfsr_d),
        .period_done (bus.period_done),
        .period_len  (bus.period_len)
    );
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: directed bench for lfsr_gen (WIDTH=8 Fibonacci) plus a width/mode
// sweep. Period-monitor checks are compiled in with LFSR_PERIOD_MON_EN.
module tb_lfsr_gen;
    import lfsr_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sweep_en = 1'b0;
    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    logic [16:0] sweep_len [0:27];
    logic        sweep_bad [0:27];

    always #5 clk = ~clk;

    lfsr_gen_if #(.WIDTH(8)) bus ();

    lfsr_gen #(
        .WIDTH (8),
        .MODE  (MODE_FIB),
        .SEED  (16'h002A)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef LFSR_PERIOD_MON_EN
    lfsr_gen_if #(.WIDTH(4)) bus4 ();

    lfsr_gen #(
        .WIDTH (4),
        .MODE  (MODE_FIB),
        .SEED  (16'h002A)
    ) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );
`endif

    // Free-running instances for every width and mode; each records the step
    // count of its first return to the seed and whether zero or lock-up was seen.
    for (genvar gm = 0; gm < 2; gm++) begin : g_mode
        for (genvar gw = 3; gw <= 16; gw++) begin : g_w
            localparam int          Idx      = gm * 14 + gw - 3;
            localparam logic [15:0] SeedFull = 16'h002A;
            logic [16:0] cnt;
            logic [16:0] first_ret;
            logic        saw_bad;

            lfsr_gen_if #(.WIDTH(gw)) sif ();
            assign sif.en      = sweep_en;
            assign sif.load    = 1'b0;
            assign sif.seed_in = '0;

            lfsr_gen #(
                .WIDTH (gw),
                .MODE  (gm),
                .SEED  (SeedFull)
            ) u_dut (
                .clk (clk),
                .rst (rst),
                .bus (sif)
            );

            always @(posedge clk) begin
                if (rst) begin
                    cnt       <= '0;
                    first_ret <= '0;
                    saw_bad   <= 1'b0;
                end else if (sweep_en) begin
                    if (sif.lfsr == SeedFull[gw-1:0] && cnt != 0 && first_ret == 0) begin
                        first_ret <= cnt;
                    end
                    if (sif.lfsr == '0 || sif.lockup) begin
                        saw_bad <= 1'b1;
                    end
                    cnt <= cnt + 1'b1;
                end
            end

            assign sweep_len[Idx] = first_ret;
            assign sweep_bad[Idx] = saw_bad;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  model;
        int unsigned steps;
        int unsigned bad;
        int unsigned done_cnt;
        int unsigned done_step;
        logic [7:0]  done_len;

        bus.en = 1'b0;
        bus.load = 1'b0;
        bus.seed_in = '0;
`ifdef LFSR_PERIOD_MON_EN
        bus4.en = 1'b0;
        bus4.load = 1'b0;
        bus4.seed_in = '0;
`endif
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        check("reset_lfsr", 32'(bus.lfsr), 32'h2A);
        check("reset_lockup", 32'(bus.lockup), 32'h0);
        check("reset_bit_out", 32'(bus.bit_out), 32'h0);
`ifdef LFSR_PERIOD_MON_EN
        check("reset_period_done", 32'(bus.period_done), 32'h0);
        check("reset_period_len", 32'(bus.period_len), 32'h0);
`endif

        // Full period against a bench model of x^8+x^6+x^5+x^4+1.
        model = 8'h2A;
        steps = 0;
        bad = 0;
        done_cnt = 0;
        done_step = 0;
        done_len = '0;
        bus.en = 1'b1;
        while (steps == 0 || (bus.lfsr !== 8'h2A && steps < 300)) begin
            tick();
            steps++;
            model = {model[6:0], model[7] ^ model[5] ^ model[4] ^ model[3]};
            if (bus.lfsr !== model) bad++;
            if (bus.bit_out !== model[7]) bad++;
            if (steps == 1) check("step1", 32'(bus.lfsr), 32'h54);
            if (steps == 2) check("step2", 32'(bus.lfsr), 32'hA9);
            if (steps == 2) check("step2_bit_out", 32'(bus.bit_out), 32'h1);
            if (steps == 3) check("step3", 32'(bus.lfsr), 32'h53);
`ifdef LFSR_PERIOD_MON_EN
            if (bus.period_done === 1'b1) begin
                done_cnt++;
                done_step = steps;
                done_len = bus.period_len;
            end
`endif
        end
        bus.en = 1'b0;
        check("period_steps", steps, 255);
        check("model_track", bad, 0);
`ifdef LFSR_PERIOD_MON_EN
        check("mon8_done_count", done_cnt, 1);
        check("mon8_done_step", done_step, 255);
        check("mon8_len", 32'(done_len), 255);
`endif

        // en pattern 1,0,0,1 from 0x2A.
        bus.en = 1'b1; tick(); check("toggle_step", 32'(bus.lfsr), 32'h54);
        bus.en = 1'b0; tick(); check("toggle_hold1", 32'(bus.lfsr), 32'h54);
        tick();                check("toggle_hold2", 32'(bus.lfsr), 32'h54);
        check("toggle_hold_lockup", 32'(bus.lockup), 32'h0);
        bus.en = 1'b1; tick(); check("toggle_step2", 32'(bus.lfsr), 32'hA9);

        // load and en together: load wins, no step.
        bus.load = 1'b1; bus.seed_in = 8'h01; tick();
        check("load_wins", 32'(bus.lfsr), 32'h01);
        check("load_no_lockup", 32'(bus.lockup), 32'h0);
        bus.load = 1'b0; tick();
        check("step_after_load", 32'(bus.lfsr), 32'h02);
        bus.en = 1'b0;

        // Zero seed falls back to SEED with a single lockup pulse.
        bus.load = 1'b1; bus.seed_in = 8'h00; tick();
        check("zero_load_lfsr", 32'(bus.lfsr), 32'h2A);
        check("zero_load_lockup", 32'(bus.lockup), 32'h1);
        bus.load = 1'b0; tick();
        check("zero_load_pulse_end", 32'(bus.lockup), 32'h0);
        check("zero_load_hold", 32'(bus.lfsr), 32'h2A);

        // Deposit the all-zero state and step into it.
        dut.lfsr_q <= '0;
        bus.en = 1'b1; tick();
        check("deposit_recover_lfsr", 32'(bus.lfsr), 32'h2A);
        check("deposit_recover_lockup", 32'(bus.lockup), 32'h1);
        bus.en = 1'b0; tick();
        check("deposit_pulse_end", 32'(bus.lockup), 32'h0);

        // Reset mid-run dominates en and load.
        bus.en = 1'b1; tick(); tick();
        check("pre_rst", 32'(bus.lfsr), 32'hA9);
        rst = 1'b1; bus.load = 1'b1; bus.seed_in = 8'h77; tick();
        check("rst_mid_run", 32'(bus.lfsr), 32'h2A);
        check("rst_mid_run_lockup", 32'(bus.lockup), 32'h0);
        rst = 1'b0; bus.load = 1'b0; bus.en = 1'b0;

`ifdef LFSR_PERIOD_MON_EN
        // WIDTH=4 from seed 0x9: done after 15 steps; reload mid-period restarts.
        bus4.load = 1'b1; bus4.seed_in = 4'h9; tick();
        bus4.load = 1'b0; bus4.en = 1'b1;
        done_cnt = 0; done_step = 0; done_len = '0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (bus4.period_done === 1'b1) begin
                done_cnt++;
                done_step = k;
                done_len = 8'(bus4.period_len);
            end
        end
        check("mon4_done_count", done_cnt, 1);
        check("mon4_done_step", done_step, 15);
        check("mon4_len", 32'(done_len), 15);
        repeat (5) tick();
        bus4.load = 1'b1; bus4.seed_in = 4'h9; tick();
        bus4.load = 1'b0;
        done_cnt = 0; done_step = 0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (bus4.period_done === 1'b1) begin
                done_cnt++;
                done_step = k;
            end
        end
        check("mon4_reload_done_count", done_cnt, 1);
        check("mon4_reload_done_step", done_step, 15);
        check("mon4_reload_len", 32'(bus4.period_len), 15);
        bus4.en = 1'b0;
`endif

        // Width/mode sweep: first return to seed after 2^W-1 steps, never zero.
        rst = 1'b1; tick();
        rst = 1'b0; sweep_en = 1'b1;
        repeat (65540) tick();
        sweep_en = 1'b0;
        for (int i = 0; i < 28; i++) begin
            int w;
            w = 3 + (i % 14);
            check($sformatf("sweep_len_m%0d_w%0d", i / 14, w), 32'(sweep_len[i]),
                  (32'd1 << w) - 32'd1);
            check($sformatf("sweep_zero_m%0d_w%0d", i / 14, w), 32'(sweep_bad[i]), 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
